// File: rtl/mux41_arb_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Timeout option: MUX41_ARB_TIMEOUT_EN (see mux41_rr_arb).
package mux41_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ  = 4;
  localparam int IDXW  = 2;
  localparam int HOLDW = 4;

  function automatic logic [NREQ-1:0] onehot(
    input logic [IDXW-1:0] idx
  );
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux41_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr,
// skipping any bit set in the exclude mask.
module mux41_rr_pick
  import mux41_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  input  logic [NREQ-1:0] i_excl,
  output logic            o_found,
  output logic [IDXW-1:0] o_idx
);

  logic [IDXW-1:0] w_cand;

  // Scan from the far end so the nearest candidate wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + IDXW'(k);
      if (i_req[w_cand] && !i_excl[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter driving the select of a 4-bit 4:1 mux.
// Define MUX41_ARB_TIMEOUT_EN to rotate owners after MAX_HOLD cycles.
module mux41_rr_arb
  import mux41_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      a,
  input  logic [3:0]      b,
  input  logic [3:0]      c,
  input  logic [3:0]      d,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] sel,
  output logic [3:0]      y,
  output logic            valid
);

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);

  state_t           r_state, w_state;
  logic [IDXW-1:0]  r_ptr, w_ptr;
  logic [HOLDW-1:0] r_hold, w_hold;
  logic [NREQ-1:0]  r_gnt, w_gnt;
  logic [IDXW-1:0]  r_sel, w_sel;
  logic             r_valid, w_valid;

  logic             w_found;
  logic [IDXW-1:0]  w_idx;
  logic [NREQ-1:0]  w_excl;
  logic             w_take;
  logic [3:0]       w_mux;

  // Excluding the owner is harmless on release (its req is low)
  // and is exactly what the timeout handover needs.
  assign w_excl = (r_state == GRANT) ? onehot(r_sel) : '0;

  mux41_rr_pick u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    w_gnt   = r_gnt;
    w_sel   = r_sel;
    w_valid = r_valid;
    w_take  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_take = 1'b1;
        end else begin
          w_gnt   = '0;
          w_valid = 1'b0;
        end
      end
      GRANT: begin
        if (!req[r_sel]) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state = IDLE;
            w_gnt   = '0;
            w_valid = 1'b0;
          end
        end else if (TO_EN && r_hold == HOLD_LAST) begin
          if (w_found) w_take = 1'b1;
          else         w_hold = '0;
        end else if (r_hold != '1) begin
          w_hold = r_hold + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_take) begin
      w_state = GRANT;
      w_sel   = w_idx;
      w_gnt   = onehot(w_idx);
      w_valid = 1'b1;
      w_ptr   = w_idx + 1'b1;
      w_hold  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_valid <= w_valid;
    end
  end

  always_comb begin
    unique case (r_sel)
      2'd0:    w_mux = a;
      2'd1:    w_mux = b;
      2'd2:    w_mux = c;
      default: w_mux = d;
    endcase
  end

  assign y     = r_valid ? w_mux : 4'h0;
  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Scoreboard bench for mux41_rr_arb; expected outputs are queued per
// edge by the stimulus and popped by an independent monitor.
module tb_mux41_rr_arb;

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       v;
    logic [3:0] y;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a, b, c, d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] y;
  logic       valid;

  logic [3:0] dw [4];
  exp_t       q [$];
  int         checks = 0;
  int         fails  = 0;

  mux41_rr_arb #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic set_data(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
    dw[0] = d0; dw[1] = d1; dw[2] = d2; dw[3] = d3;
    a = d0; b = d1; c = d2; d = d3;
  endtask

  // Apply inputs for the next edge and queue what must appear after it.
  task automatic step(input logic rst, input logic [3:0] rq,
                      input logic v, input logic [1:0] s,
                      input string nm);
    exp_t e;
    rst_n  = rst;
    req    = rq;
    e.gnt  = v ? (4'b0001 << s) : 4'b0000;
    e.sel  = s;
    e.v    = v;
    e.y    = v ? dw[s] : 4'h0;
    e.name = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (gnt !== e.gnt || sel !== e.sel || valid !== e.v || y !== e.y) begin
          fails++;
          $display("FAIL %s: gnt=%b sel=%0d valid=%b y=%h, want gnt=%b sel=%0d valid=%b y=%h",
                   e.name, gnt, sel, valid, y, e.gnt, e.sel, e.v, e.y);
        end
        checks++;
        if ($countones(gnt) > 1) begin
          fails++;
          $display("FAIL onehot %s: gnt=%b, want at most one bit", e.name, gnt);
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    req   = 4'b0000;
    set_data(4'h5, 4'h0, 4'h0, 4'h0);
    @(negedge clk);

    step(0, 4'b1111, 0, 0, "reset0");
    step(0, 4'b1111, 0, 0, "reset1");

    step(1, 4'b0001, 1, 0, "single_grant");
    step(1, 4'b0001, 1, 0, "single_hold");
    step(1, 4'b0000, 0, 0, "single_release");
    step(1, 4'b0000, 0, 0, "idle_stay");

    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    step(0, 4'b0000, 0, 0, "reset_rr");
    step(1, 4'b1111, 1, 0, "rr0");
    step(1, 4'b1110, 1, 1, "rr1");
    step(1, 4'b1101, 1, 2, "rr2");
    step(1, 4'b1011, 1, 3, "rr3");
    step(1, 4'b0111, 1, 0, "rr0_again");

    step(1, 4'b1000, 1, 3, "to_owner3");
    step(1, 4'b0000, 0, 3, "idle_sel_holds");
    step(1, 4'b1001, 1, 0, "ptr_wrap");
    step(1, 4'b0000, 0, 0, "wrap_release");

    step(0, 4'b0000, 0, 0, "reset_hold");
    for (int i = 0; i < 10; i++)
      step(1, 4'b0011, 1, TO ? 2'((i / 4) % 2) : 2'd0, "hold_pair");
    for (int i = 0; i < 20; i++)
      step(1, 4'b0001, 1, 0, "hold_alone");
    step(1, 4'b0000, 0, 0, "hold_release");

    step(1, 4'b0100, 1, 2, "owner2");
    step(1, 4'b0100, 1, 2, "owner2_hold");
    step(0, 4'b0100, 0, 0, "reset_mid_grant");
    step(1, 4'b0100, 1, 2, "regrant2");
    step(1, 4'b1011, 1, 3, "after2_ptr3");
    step(0, 4'b1110, 0, 0, "reset_ptr");
    step(1, 4'b1110, 1, 1, "ptr_from0");
    step(1, 4'b0000, 0, 1, "final_idle");

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
